gate_truth_sweep: RTL
=====================

# gate_truth_sweep

Parametrised, self-running truth-table engine for an N-input logic gate with selectable operation. On `start` it walks every input combination from 0 to 2^N_IN−1, holds each for HOLD cycles, and captures the gate output into a table vector with a ones count. It is the synthesizable successor to the fixed two-input AND stimulus bench: the same exhaustive-sweep check, now in hardware, generalised in input count, gate type and dwell time. It sits beside the gate library as a built-in self-check and waveform source.

## Interface
- `N_IN`, default 2: gate input count; legal range 2..6.
- `HOLD`, default 1: cycles each input vector is held; legal range 1..255.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: sweep request; sampled on the rising edge of `clk`.
- `op`  in  3: gate select, latched when a start is accepted. 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6–7 reserved (output 0).
- `busy`  out  1: high while a sweep is running.
- `done`  out  1: one-cycle pulse when the sweep completes.
- `cur_in`  out  N_IN: input vector currently applied to the gate.
- `cur_out`  out  1: combinational gate output for `cur_in` under the latched op.
- `table`  out  2**N_IN: bit k = gate output for input vector k.
- `ones_cnt`  out  N_IN+1: number of 1 bits captured into `table`.

## Operation
- States: IDLE, RUN, DONE.
- Reset, asynchronous: state=IDLE, and `busy`, `done`, `cur_in`, `table`, `ones_cnt`, latched op and hold counter all 0.
- IDLE: when `start`=1, latch `op`, clear `table`/`ones_cnt`, set `cur_in`=0, clear the hold counter, go to RUN.
- RUN: the hold counter counts 0..HOLD−1.
  - On the cycle where count = HOLD−1: write `cur_out` into `table[cur_in]` and add it to `ones_cnt`.
  - If `cur_in` = 2^N_IN−1: go to DONE. Otherwise increment `cur_in` and clear the counter.
- DONE: `done`=1 and `busy`=0 for one cycle, then return to IDLE.
  - A `start` in the DONE cycle is accepted as in IDLE, with RUN entered on the next edge.
- Start while in RUN: ignored. Changes to `op` during RUN: ignored, because the latched copy is used.
- Width rules:
  - `cur_in` holds at 2^N_IN−1 after the last vector and does not wrap to 0 until the next start.
  - `ones_cnt` maximum is 2^N_IN, which fits in N_IN+1 bits.
- Reserved op: the sweep runs normally; `table`=0 and `ones_cnt`=0.
- `table` and `ones_cnt` hold their values after DONE until the next accepted start.
- Reset mid-sweep aborts immediately with reset values; no `done` pulse is produced.

## Timing
- Start sampled at edge 0 → edge 1: `busy`=1, `cur_in`=0.
- Vector k is applied from edge 1+k·HOLD through edge (k+1)·HOLD and captured at the end of its last cycle.
- `busy` is high for exactly 2^N_IN·HOLD cycles.
- `done` is high on the cycle starting at edge 2^N_IN·HOLD+1; `table` is final in that cycle.
- Start-to-done latency: 2^N_IN·HOLD+1 cycles.
- `cur_out` has zero latency from `cur_in` and the latched op (combinational).
- Minimum period between accepted starts: 2^N_IN·HOLD+1 cycles, using restart from DONE.

## Test plan
- N_IN=2, HOLD=1, op=0 (AND), one start pulse → `cur_in` steps 0,1,2,3 on consecutive cycles; `done` pulses 5 cycles after start; `table`=4'b1000, `ones_cnt`=1.
- N_IN=3, HOLD=1, op=2 (XOR) → `table`=8'b1001_0110, `ones_cnt`=4. Repeat with op=5 (XNOR) → `table`=8'b0110_1001, `ones_cnt`=4.
- N_IN=2, HOLD=3, op=4 (NOR) → `busy` high for 12 cycles, each `cur_in` value stable for 3 cycles; `table`=4'b0001, `ones_cnt`=1.
- During a run, pulse `start` and switch `op` from 1 to 0 → no restart; result is the OR table 4'b1110, `ones_cnt`=3; `done` pulses exactly once.
- Assert `rst` asynchronously between clock edges, mid-sweep at vector 2 → all outputs 0 immediately; no `done`; a following start yields a correct full sweep.
- `start` held high continuously, op=3 (NAND), N_IN=2, HOLD=1 → back-to-back sweeps every 5 cycles, each giving `table`=4'b0111, `ones_cnt`=3. Also op=7 (reserved) → `table`=0, `ones_cnt`=0, normal `done` timing.

Source files
------------

// File: rtl/gate_truth_sweep.sv
// gate_truth_sweep: exhaustive truth-table sweep of a selectable N-input gate
module gate_truth_sweep #(
  parameter int N_IN = 2,
  parameter int HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN-1:0]      cur_in,
  output logic                 cur_out,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        ones_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_q;
  logic [7:0] cnt;
  logic accept, hold_end, last_vec;
  assign accept = start && state != RUN;
  assign hold_end = cnt == 8'(HOLD - 1);
  assign last_vec = &cur_in;
  assign busy = state == RUN;
  assign done = state == DONE;
  // gate evaluation of the applied vector under the latched op; reserved ops give 0
  always_comb begin
    cur_out = op_q == 3'd0 ? &cur_in :
              op_q == 3'd1 ? |cur_in :
              op_q == 3'd2 ? ^cur_in :
              op_q == 3'd3 ? ~&cur_in :
              op_q == 3'd4 ? ~|cur_in :
              op_q == 3'd5 ? ~^cur_in : 1'b0;
  end
  // next state: start accepted outside RUN, last capture ends the sweep, DONE lasts one cycle
  always_comb begin
    state_n = state;
    if (accept) state_n = RUN;
    else if (state == RUN && hold_end && last_vec) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // sweep datapath: latch op on start, dwell HOLD cycles per vector, capture on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      cnt <= '0;
      cur_in <= '0;
      truth_table <= '0;
      ones_cnt <= '0;
    end else if (accept) begin
      op_q <= op;
      cnt <= '0;
      cur_in <= '0;
      truth_table <= '0;
      ones_cnt <= '0;
    end else if (state == RUN) begin
      if (hold_end) begin
        truth_table[cur_in] <= cur_out;
        ones_cnt <= ones_cnt + {{N_IN{1'b0}}, cur_out};
        if (!last_vec) begin
          cur_in <= cur_in + 1'b1;
          cnt <= '0;
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule
